bsg_wormhole_router_output_control_credited: RTL and testbench

BSG_WORMHOLE_ROUTER_OUTPUT_CONTROL_CREDITED -- requirements
Module: bsg_wormhole_router_output_control_credited

---
 rtl/bsg_wormhole_router_output_control_credited_pkg.sv | 15 +
 rtl/bsg_round_robin_arb_en.sv | 59 +++++
 rtl/bsg_wormhole_router_output_control_credited.sv | 93 +++++++++
 tb/tb_bsg_wormhole_router_output_control_credited.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bsg_wormhole_router_output_control_credited_pkg.sv
// rtl/bsg_wormhole_router_output_control_credited_pkg.sv - shared helpers for the credited output control
// Contents:
//   cnt_width - bits needed to hold a credit count in 0..max_credits
//   wrap_inc  - round-robin index increment modulo n
package bsg_wormhole_router_output_control_credited_pkg;

    function automatic int unsigned cnt_width(input int unsigned max_credits);
        return $clog2(max_credits + 1);
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bsg_round_robin_arb_en.sv
// rtl/bsg_round_robin_arb_en.sv - round-robin arbiter with grant enable and yumi-driven pointer advance
// Ports:
//   clk_i, reset_i  - clock, asynchronous active-high reset (pointer -> input 0 highest priority)
//   grants_en_i     - when 0 all grants are forced to 0
//   reqs_i          - per-input requests
//   grants_o        - one-hot-or-zero grant
//   yumi_i          - the current grant was used; the winner becomes lowest priority
module bsg_round_robin_arb_en
    import bsg_wormhole_router_output_control_credited_pkg::*;
#(
    parameter int input_dirs_p = 5
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    grants_en_i,
    input  logic [input_dirs_p-1:0] reqs_i,
    output logic [input_dirs_p-1:0] grants_o,
    input  logic                    yumi_i
);

    localparam int ptr_w_lp = $clog2(input_dirs_p);

    // hi_r holds the index of the highest-priority input
    logic [ptr_w_lp-1:0]     hi_r;
    logic [ptr_w_lp-1:0]     win_idx;
    logic [input_dirs_p-1:0] grant_raw;
    logic                    found;
    int                      idx;

    // Scan from hi_r upward with wrap; first requester wins
    always_comb begin
        grant_raw = '0;
        win_idx   = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < input_dirs_p; k++) begin
            idx = int'(hi_r) + k;
            if (idx >= input_dirs_p) begin
                idx = idx - input_dirs_p;
            end
            if (!found && reqs_i[idx]) begin
                found          = 1'b1;
                grant_raw[idx] = 1'b1;
                win_idx        = ptr_w_lp'(idx);
            end
        end
    end

    assign grants_o = grants_en_i ? grant_raw : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hi_r <= '0;
        end else if (yumi_i) begin
            hi_r <= ptr_w_lp'(wrap_inc(32'(win_idx), input_dirs_p));
        end
    end

endmodule

// File: rtl/bsg_wormhole_router_output_control_credited.sv
// rtl/bsg_wormhole_router_output_control_credited.sv - wormhole output port control with downstream credit counting
// Ports:
//   clk_i, reset_i  - clock, asynchronous active-high reset
//   reqs_i          - per-input header request for this output
//   release_i       - per-input path release (cycle after that input's tail flit)
//   valid_i         - per-input flit available
//   yumi_o          - per-input flit consumed
//   data_sel_o      - one-hot-or-zero select for the output datapath mux
//   valid_o         - a flit leaves on the output this cycle
//   credit_i        - one downstream credit returned
//   credit_count_o  - current credit count
module bsg_wormhole_router_output_control_credited
    import bsg_wormhole_router_output_control_credited_pkg::*;
#(
    parameter int input_dirs_p  = 5,
    parameter int max_credits_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [input_dirs_p-1:0] reqs_i,
    input  logic [input_dirs_p-1:0] release_i,
    input  logic [input_dirs_p-1:0] valid_i,
    output logic [input_dirs_p-1:0] yumi_o,
    output logic [input_dirs_p-1:0] data_sel_o,
    output logic                    valid_o,
    input  logic                    credit_i,
    output logic [$clog2(max_credits_p+1)-1:0] credit_count_o
);

    localparam int                 cnt_w_lp   = cnt_width(max_credits_p);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_credits_p);

    logic [input_dirs_p-1:0] scheduled_r;
    logic [input_dirs_p-1:0] sched_rel;
    logic [input_dirs_p-1:0] grants;
    logic [input_dirs_p-1:0] sel_valid;
    logic                    free;
    logic                    have_credit;
    logic [cnt_w_lp-1:0]     credit_r;

    // A release only matters for the input that actually owns the path
    assign sched_rel = scheduled_r & ~release_i;
    assign free      = ~(|sched_rel);

    bsg_round_robin_arb_en #(
        .input_dirs_p(input_dirs_p)
    ) arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .grants_en_i(free),
        .reqs_i     (reqs_i),
        .grants_o   (grants),
        .yumi_i     (free & valid_o)
    );

    // grants is zero whenever sched_rel is non-zero, so this stays one-hot-or-zero
    assign data_sel_o  = grants | sched_rel;
    assign have_credit = (credit_r != '0);
    assign sel_valid   = data_sel_o & valid_i;
    assign valid_o     = have_credit & (|sel_valid);
    assign yumi_o      = have_credit ? sel_valid : '0;
    assign credit_count_o = credit_r;

    // Ownership is kept even on cycles with no flit or no credit
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            scheduled_r <= '0;
        end else begin
            scheduled_r <= data_sel_o;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credit_r <= max_cnt_lp;
        end else if (credit_i && !valid_o) begin
            if (credit_r != max_cnt_lp) begin
                credit_r <= credit_r + cnt_w_lp'(1);
            end
        end else if (!credit_i && valid_o) begin
            credit_r <= credit_r - cnt_w_lp'(1);
        end
    end

    // A credit returned while already full means the downstream returned more than it was given
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(credit_i && !valid_o && credit_r == max_cnt_lp))
                else $warning("credit overflow: credit_i at max count with no send");
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_router_output_control_credited.sv
// tb/tb_bsg_wormhole_router_output_control_credited.sv - directed table-driven bench for the credited output control
module tb_bsg_wormhole_router_output_control_credited;

    logic       clk_i;
    logic       reset_i;
    logic [4:0] reqs_i;
    logic [4:0] release_i;
    logic [4:0] valid_i;
    logic [4:0] yumi_o;
    logic [4:0] data_sel_o;
    logic       valid_o;
    logic       credit_i;
    logic [2:0] credit_count_o;

    bsg_wormhole_router_output_control_credited #(
        .input_dirs_p (5),
        .max_credits_p(4)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .reqs_i        (reqs_i),
        .release_i     (release_i),
        .valid_i       (valid_i),
        .yumi_o        (yumi_o),
        .data_sel_o    (data_sel_o),
        .valid_o       (valid_o),
        .credit_i      (credit_i),
        .credit_count_o(credit_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic [4:0] reqs;
        logic [4:0] rel;
        logic [4:0] vld;
        logic       crd;
        logic [4:0] e_sel;
        logic [4:0] e_yumi;
        logic       e_v;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rst, logic [4:0] reqs, logic [4:0] rel, logic [4:0] vld, logic crd,
                                logic [4:0] e_sel, logic [4:0] e_yumi, logic e_v, logic [2:0] e_cnt);
        vec_t v;
        v.rst = rst; v.reqs = reqs; v.rel = rel; v.vld = vld; v.crd = crd;
        v.e_sel = e_sel; v.e_yumi = e_yumi; v.e_v = e_v; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input int step, input logic [4:0] e_sel, input logic [4:0] e_yumi,
                             input logic e_v, input logic [2:0] e_cnt);
        check("data_sel", step, 32'(data_sel_o), 32'(e_sel));
        check("yumi", step, 32'(yumi_o), 32'(e_yumi));
        check("valid", step, 32'(valid_o), 32'(e_v));
        check("count", step, 32'(credit_count_o), 32'(e_cnt));
    endtask

    initial begin
        // reset check after release
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3'd4));
        // single packet on input 2, three flits then release
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 0, 5'b00100, 5'b00100, 1, 3'd4));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00100, 0, 5'b00100, 5'b00100, 1, 3'd3));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00100, 0, 5'b00100, 5'b00100, 1, 3'd2));
        tbl.push_back(mk(0, 5'b00000, 5'b00100, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3'd1));
        // refill
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd1));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd2));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd3));
        // credit exhaustion on input 1
        tbl.push_back(mk(0, 5'b00010, 5'b00000, 5'b00010, 0, 5'b00010, 5'b00010, 1, 3'd4));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 0, 5'b00010, 5'b00010, 1, 3'd3));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 0, 5'b00010, 5'b00010, 1, 3'd2));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 0, 5'b00010, 5'b00010, 1, 3'd1));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 0, 5'b00010, 5'b00000, 0, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 1, 5'b00010, 5'b00000, 0, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00010, 0, 5'b00010, 5'b00010, 1, 3'd1));
        tbl.push_back(mk(0, 5'b00000, 5'b00010, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd0));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd1));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd2));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd3));
        // reset returns pointer to input 0
        tbl.push_back(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3'd4));
        // contention: order 0, 1, 4, 0 with grant in the release cycle
        tbl.push_back(mk(0, 5'b10011, 5'b00000, 5'b00001, 1, 5'b00001, 5'b00001, 1, 3'd4));
        tbl.push_back(mk(0, 5'b10011, 5'b00001, 5'b00010, 1, 5'b00010, 5'b00010, 1, 3'd4));
        tbl.push_back(mk(0, 5'b10011, 5'b00010, 5'b10000, 1, 5'b10000, 5'b10000, 1, 3'd4));
        tbl.push_back(mk(0, 5'b10011, 5'b10000, 5'b00001, 1, 5'b00001, 5'b00001, 1, 3'd4));
        // credit at max with no send: saturates
        tbl.push_back(mk(0, 5'b00000, 5'b00001, 5'b00000, 1, 5'b00000, 5'b00000, 0, 3'd4));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3'd4));
        // hold without valid, foreign release ignored, credit+send at 2
        tbl.push_back(mk(0, 5'b00100, 5'b00000, 5'b00100, 0, 5'b00100, 5'b00100, 1, 3'd4));
        tbl.push_back(mk(0, 5'b00000, 5'b01000, 5'b00000, 0, 5'b00100, 5'b00000, 0, 3'd3));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00100, 0, 5'b00100, 5'b00100, 1, 3'd3));
        tbl.push_back(mk(0, 5'b00000, 5'b00000, 5'b00100, 1, 5'b00100, 5'b00100, 1, 3'd2));
        tbl.push_back(mk(0, 5'b00000, 5'b00100, 5'b00000, 0, 5'b00000, 5'b00000, 0, 3'd2));

        reset_i = 1'b1; reqs_i = '0; release_i = '0; valid_i = '0; credit_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            reset_i   = tbl[i].rst;
            reqs_i    = tbl[i].reqs;
            release_i = tbl[i].rel;
            valid_i   = tbl[i].vld;
            credit_i  = tbl[i].crd;
            #2;
            check_all(i, tbl[i].e_sel, tbl[i].e_yumi, tbl[i].e_v, tbl[i].e_cnt);
        end

        // async reset mid-packet: lock input 3 with one credit left
        @(negedge clk_i);
        reset_i = 1'b0; release_i = '0; credit_i = 1'b0;
        reqs_i = 5'b01000; valid_i = 5'b01000;
        #2;
        check_all(100, 5'b01000, 5'b01000, 1, 3'd2);
        @(negedge clk_i);
        reqs_i = '0; valid_i = '0;
        #2;
        check_all(101, 5'b01000, 5'b00000, 0, 3'd1);
        #1 reset_i = 1'b1;
        #1;
        check_all(102, 5'b00000, 5'b00000, 0, 3'd4);
        // during reset only the fresh grant steers the mux
        reqs_i = 5'b00001; valid_i = 5'b00001;
        #1;
        check_all(103, 5'b00001, 5'b00001, 1, 3'd4);
        reqs_i = '0; valid_i = 5'b01000;
        #1;
        check_all(104, 5'b00000, 5'b00000, 0, 3'd4);
        reset_i = 1'b0;
        @(negedge clk_i);
        #2;
        check_all(105, 5'b00000, 5'b00000, 0, 3'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
